tmds_channel_decoder: RTL and testbench

//   Receive-side counterpart of the TMDS encode/serialize path: one instance per HDMI/DVI

---
 rtl/tmds_pkg.sv | 25 ++
 rtl/tmds_symbol_decode.sv | 33 +++
 rtl/tmds_channel_decoder.sv | 179 +++++++++++++++++
 tb/tb_tmds_channel_decoder.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Shared definitions for the TMDS receive channel: symbol/data widths,
// the four DVI control tokens, the alignment FSM states and offset stepping.
package tmds_pkg;

  localparam int unsigned SYM_W      = 10;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned OFFSET_W   = 4;

  localparam logic [SYM_W-1:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [SYM_W-1:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [SYM_W-1:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [SYM_W-1:0] CTRL_TOKEN_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } fsm_state_t;

  // Bit offsets cycle 0..9 within the 20-bit window.
  function automatic logic [OFFSET_W-1:0] next_offset(input logic [OFFSET_W-1:0] cur);
    return (cur == OFFSET_W'(SYM_W - 1)) ? '0 : cur + 1'b1;
  endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational TMDS symbol decoder: undoes the optional inversion (q[9]) and
// the XOR/XNOR transition coding (q[8]); flags the four control tokens.
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [SYM_W-1:0]  q,
  output logic [DATA_W-1:0] data,
  output logic [1:0]        ctrl,
  output logic              is_ctrl
);

  logic [DATA_W-1:0] d;

  // Data recovery plus control-token classification.
  always_comb begin
    d       = q[9] ? ~q[7:0] : q[7:0];
    data    = '0;
    data[0] = d[0];
    for (int unsigned i = 1; i < DATA_W; i++) begin
      data[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    ctrl    = '0;
    is_ctrl = 1'b1;
    case (q)
      CTRL_TOKEN_00: ctrl = 2'b00;
      CTRL_TOKEN_01: ctrl = 2'b01;
      CTRL_TOKEN_10: ctrl = 2'b10;
      CTRL_TOKEN_11: ctrl = 2'b11;
      default:       is_ctrl = 1'b0;
    endcase
  end

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS receive channel after the 1:10 deserializer: finds the 10-bit
// symbol boundary by hunting for control-token runs, then decodes symbols.
// Optional build macro TMDS_DEC_STATS_EN adds the o_lock_losses counter.
module tmds_channel_decoder
  import tmds_pkg::*;
#(
  parameter int unsigned CTRL_RUN_MIN = 8,
  parameter int unsigned SEARCH_DWELL = 2048,
  parameter int unsigned LOCK_TIMEOUT = 4096
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [SYM_W-1:0]    i_tmds,
  output logic [DATA_W-1:0]   o_data,
  output logic [1:0]          o_control,
  output logic                o_de,
  output logic                o_locked,
  output logic [OFFSET_W-1:0] o_offset
`ifdef TMDS_DEC_STATS_EN
  ,
  output logic [15:0]         o_lock_losses
`endif
);

  localparam int unsigned RUN_W   = $clog2(CTRL_RUN_MIN + 1);
  localparam int unsigned DWELL_W = (SEARCH_DWELL > 1) ? $clog2(SEARCH_DWELL) : 1;
  localparam int unsigned WD_W    = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

  localparam logic [RUN_W-1:0]   RUN_FULL   = RUN_W'(CTRL_RUN_MIN);
  localparam logic [RUN_W-1:0]   RUN_ONE    = RUN_W'(1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SEARCH_DWELL - 1);
  localparam logic [WD_W-1:0]    WD_LAST    = WD_W'(LOCK_TIMEOUT - 1);

  logic [SYM_W-1:0]    prev;
  logic [SYM_W-1:0]    sym;
  logic [SYM_W-1:0]    sym_next;
  logic [OFFSET_W-1:0] offset, offset_n;
  fsm_state_t          state, state_n;
  logic [RUN_W-1:0]    run, run_n, run_inc;
  logic [DWELL_W-1:0]  dwell, dwell_n;
  logic [WD_W-1:0]     wd, wd_n;
  logic                lost;

  logic [DATA_W-1:0]   dec_data;
  logic [1:0]          dec_ctrl;
  logic                dec_is_ctrl;

  tmds_symbol_decode u_decode (
    .q       (sym),
    .data    (dec_data),
    .ctrl    (dec_ctrl),
    .is_ctrl (dec_is_ctrl)
  );

  // Symbol extraction from the two most recent words at the current offset.
  always_comb begin
    sym_next = SYM_W'({i_tmds, prev} >> offset);
  end

  // Word history and registered symbol.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prev <= '0;
      sym  <= '0;
    end else begin
      prev <= i_tmds;
      sym  <= sym_next;
    end
  end

  // Alignment FSM: next state and counter updates from the registered symbol.
  always_comb begin
    state_n  = state;
    run_n    = run;
    dwell_n  = dwell;
    wd_n     = wd;
    offset_n = offset;
    lost     = 1'b0;
    run_inc  = (run == RUN_FULL) ? run : run + 1'b1;
    case (state)
      SEARCH: begin
        if (dec_is_ctrl) begin
          state_n = VERIFY;
          run_n   = RUN_ONE;
        end else if (dwell == DWELL_LAST) begin
          offset_n = next_offset(offset);
          dwell_n  = '0;
        end else begin
          dwell_n = dwell + 1'b1;
        end
      end
      VERIFY: begin
        if (dec_is_ctrl) begin
          run_n = run_inc;
          if (run_inc == RUN_FULL) begin
            state_n = LOCKED;
            wd_n    = '0;
          end
        end else begin
          state_n = SEARCH;
          dwell_n = '0;
          run_n   = '0;
        end
      end
      LOCKED: begin
        run_n = dec_is_ctrl ? run_inc : '0;
        if (dec_is_ctrl && (run_inc == RUN_FULL)) begin
          wd_n = '0;
        end else if (wd == WD_LAST) begin
          state_n  = SEARCH;
          offset_n = next_offset(offset);
          dwell_n  = '0;
          wd_n     = '0;
          run_n    = '0;
          lost     = 1'b1;
        end else begin
          wd_n = wd + 1'b1;
        end
      end
      default: begin
        state_n = SEARCH;
      end
    endcase
  end

  // Alignment FSM state and counter registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= SEARCH;
      run    <= '0;
      dwell  <= '0;
      wd     <= '0;
      offset <= '0;
    end else begin
      state  <= state_n;
      run    <= run_n;
      dwell  <= dwell_n;
      wd     <= wd_n;
      offset <= offset_n;
    end
  end

  // Output registers; lock flag reflects the state that judged this symbol.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_data    <= '0;
      o_control <= '0;
      o_de      <= 1'b0;
      o_locked  <= 1'b0;
    end else begin
      o_locked  <= (state == LOCKED);
      o_de      <= (state == LOCKED) && !dec_is_ctrl;
      o_data    <= ((state == LOCKED) && !dec_is_ctrl) ? dec_data : '0;
      o_control <= ((state == LOCKED) && dec_is_ctrl) ? dec_ctrl : '0;
    end
  end

  always_comb begin
    o_offset = offset;
  end

`ifdef TMDS_DEC_STATS_EN
  logic [15:0] losses;

  // Saturating count of LOCKED->SEARCH transitions.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      losses <= '0;
    end else if (lost && (losses != '1)) begin
      losses <= losses + 1'b1;
    end
  end

  always_comb begin
    o_lock_losses = losses;
  end
`endif

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Bench for tmds_channel_decoder: a DVI encoder and bit-rotating serial
// stream feed the DUT; a behavioural model predicts every output each cycle
// and a byte scoreboard confirms encoded video data comes back in order.
module tb_tmds_channel_decoder;

  localparam int RUN_MIN = 8;
  localparam int DWELL   = 2048;
  localparam int TIMEOUT = 4096;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] tmds = '0;
  logic [7:0] o_data;
  logic [1:0] o_control;
  logic       o_de;
  logic       o_locked;
  logic [3:0] o_offset;
`ifdef TMDS_DEC_STATS_EN
  logic [15:0] lock_losses;
`endif

  always #5 clk = ~clk;

  tmds_channel_decoder #(
    .CTRL_RUN_MIN (RUN_MIN),
    .SEARCH_DWELL (DWELL),
    .LOCK_TIMEOUT (TIMEOUT)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_tmds    (tmds),
    .o_data    (o_data),
    .o_control (o_control),
    .o_de      (o_de),
    .o_locked  (o_locked),
    .o_offset  (o_offset)
`ifdef TMDS_DEC_STATS_EN
    ,
    .o_lock_losses (lock_losses)
`endif
  );

  int n_total = 0;
  int n_bad   = 0;

  logic [9:0] tok [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

  // stream state
  int         rot = 0;
  logic [9:0] last_sym = 10'b1101010100;
  int         disp = 0;
  bit         sb_en = 1'b0;
  int         exp_q[$];

  // model state: phase 0 hunting, 1 confirming, 2 aligned
  int m_prev, m_sym, m_phase, m_run, m_dwell, m_wd, m_off, m_losses;
  int e_data, e_ctrl, e_de, e_locked;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic ref_decode(input logic [9:0] q, output int data, output int ctrl, output bit isc);
    logic [7:0] d;
    logic [7:0] r;
    d = q[9] ? ~q[7:0] : q[7:0];
    r[0] = d[0];
    for (int i = 1; i < 8; i++) r[i] = q[8] ? (d[i] ^ d[i-1]) : !(d[i] ^ d[i-1]);
    data = int'(r);
    ctrl = 0;
    isc  = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (q == tok[c]) begin
        ctrl = c;
        isc  = 1'b1;
      end
    end
  endtask

  task automatic model_step(input logic [9:0] word, input bit r);
    int d, c, nsym;
    bit isc;
    if (r) begin
      m_prev = 0; m_sym = 0; m_phase = 0; m_run = 0; m_dwell = 0; m_wd = 0;
      m_off = 0; m_losses = 0;
      e_data = 0; e_ctrl = 0; e_de = 0; e_locked = 0;
      return;
    end
    ref_decode(m_sym[9:0], d, c, isc);
    e_locked = (m_phase == 2) ? 1 : 0;
    e_de     = (e_locked == 1 && !isc) ? 1 : 0;
    e_data   = (e_de == 1) ? d : 0;
    e_ctrl   = (e_locked == 1 && isc) ? c : 0;
    nsym     = ((int'(word) * 1024 + m_prev) >> m_off) % 1024;
    m_prev   = int'(word);
    if (m_phase == 0) begin
      if (isc) begin
        m_phase = 1; m_run = 1;
      end else if (m_dwell == DWELL - 1) begin
        m_off = (m_off + 1) % 10; m_dwell = 0;
      end else begin
        m_dwell++;
      end
    end else if (m_phase == 1) begin
      if (isc) begin
        m_run++;
        if (m_run >= RUN_MIN) begin
          m_phase = 2; m_wd = 0;
        end
      end else begin
        m_phase = 0; m_dwell = 0;
      end
    end else begin
      m_run = isc ? ((m_run + 1 > RUN_MIN) ? RUN_MIN : m_run + 1) : 0;
      if (isc && m_run == RUN_MIN) begin
        m_wd = 0;
      end else if (m_wd == TIMEOUT - 1) begin
        m_phase = 0; m_off = (m_off + 1) % 10; m_dwell = 0; m_wd = 0;
        if (m_losses < 65535) m_losses++;
      end else begin
        m_wd++;
      end
    end
    m_sym = nsym;
  endtask

  task automatic tick(input logic [9:0] word, input bit r);
    tmds = word;
    rst  = r;
    @(posedge clk);
    #1;
    model_step(word, r);
    check("data", o_data, e_data);
    check("control", o_control, e_ctrl);
    check("de", o_de, e_de);
    check("locked", o_locked, e_locked);
    check("offset", o_offset, m_off);
`ifdef TMDS_DEC_STATS_EN
    check("lock_losses", lock_losses, m_losses);
`endif
    if (!r && sb_en && o_de === 1'b1) begin
      if (exp_q.size() == 0) check("sb_underrun", exp_q.size(), 1);
      else check("sb_byte", o_data, exp_q.pop_front());
    end
  endtask

  task automatic send_sym(input logic [9:0] s, input bit r);
    logic [19:0] pair;
    logic [9:0]  word;
    pair     = {s, last_sym};
    word     = 10'(pair >> (10 - rot));
    last_sym = s;
    tick(word, r);
  endtask

  task automatic send_ctrl(input int c, input bit r);
    disp = 0;
    send_sym(tok[c], r);
  endtask

  task automatic encode(input logic [7:0] b, output logic [9:0] q);
    logic [8:0] qm;
    int n1, n1q, n0q;
    bit use_xnor;
    n1 = $countones(b);
    use_xnor = (n1 > 4) || (n1 == 4 && !b[0]);
    qm[0] = b[0];
    for (int i = 1; i < 8; i++) qm[i] = use_xnor ? !(qm[i-1] ^ b[i]) : (qm[i-1] ^ b[i]);
    qm[8] = !use_xnor;
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (disp == 0 || n1q == n0q) begin
      q = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      disp += qm[8] ? (n1q - n0q) : (n0q - n1q);
    end else if ((disp > 0 && n1q > n0q) || (disp < 0 && n0q > n1q)) begin
      q = {1'b1, qm[8], ~qm[7:0]};
      disp += 2 * int'(qm[8]) + n0q - n1q;
    end else begin
      q = {1'b0, qm[8], qm[7:0]};
      disp += -2 * int'(!qm[8]) + n1q - n0q;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] q;
    encode(b, q);
    if (sb_en) exp_q.push_back(int'(b));
    send_sym(q, 1'b0);
  endtask

  initial begin
    int n;
    int pick;

    // reset with random words on the wire
    for (int i = 0; i < 3; i++) begin
      tick(10'($urandom), 1'b1);
      check("rst_data", o_data, 0);
      check("rst_de", o_de, 0);
      check("rst_locked", o_locked, 0);
      check("rst_offset", o_offset, 0);
    end

    // aligned stream: token run, then every byte value
    rot = 0;
    for (int i = 0; i < 16; i++) send_ctrl(0, 1'b0);
    check("lock0", o_locked, 1);
    check("lock0_offset", o_offset, 0);
    sb_en = 1'b1;
    for (int b = 0; b < 256; b++) send_byte(8'(b));
    for (int i = 0; i < 3; i++) send_ctrl(0, 1'b0);
    check("sb_drained0", exp_q.size(), 0);
    sb_en = 1'b0;

    // control values while locked
    send_ctrl(1, 1'b0);
    send_ctrl(3, 1'b0);
    send_ctrl(0, 1'b0);
    check("ctrl01_de", o_de, 0);
    check("ctrl01_val", o_control, 2'b01);
    send_ctrl(0, 1'b0);
    check("ctrl11_de", o_de, 0);
    check("ctrl11_val", o_control, 2'b11);

    // watchdog: data only until lock is lost
    for (int i = 0; i < 10; i++) send_ctrl(0, 1'b0);
    for (int i = 0; i < TIMEOUT + 4; i++) send_byte(8'($urandom));
    check("timeout_locked", o_locked, 0);
    check("timeout_offset", o_offset, 1);
`ifdef TMDS_DEC_STATS_EN
    check("timeout_losses", lock_losses, 1);
`endif

    // stream rotated by 3 bits: lock found by offset search
    rot = 3;
    for (int i = 0; i < 3; i++) send_ctrl(0, 1'b1);
    n = 0;
    while (o_locked !== 1'b1 && n < 3 * DWELL + RUN_MIN + 3) begin
      send_ctrl(0, 1'b0);
      n++;
    end
    check("lock3", o_locked, 1);
    check("lock3_offset", o_offset, 3);
    sb_en = 1'b1;
    for (int b = 0; b < 256; b++) send_byte(8'(b));
    for (int i = 0; i < 4; i++) send_ctrl(0, 1'b0);
    check("sb_drained3", exp_q.size(), 0);
    sb_en = 1'b0;

    // short token run interrupted in VERIFY, then reset while locked
    rot = 0;
    for (int i = 0; i < 3; i++) send_ctrl(2, 1'b1);
    for (int i = 0; i < 7; i++) send_ctrl(2, 1'b0);
    for (int i = 0; i < 20; i++) send_byte(8'($urandom));
    check("short_run_locked", o_locked, 0);
    for (int i = 0; i < 12; i++) send_ctrl(2, 1'b0);
    check("relock_a", o_locked, 1);
    send_ctrl(2, 1'b1);
    check("midrst_locked", o_locked, 0);
    check("midrst_control", o_control, 0);
    check("midrst_offset", o_offset, 0);
    for (int i = 0; i < 12; i++) send_ctrl(2, 1'b0);
    check("relock_b", o_locked, 1);

    // random mix of tokens, video bytes and raw words
    for (int i = 0; i < 600; i++) begin
      pick = $urandom_range(0, 9);
      if (pick < 2)      send_ctrl($urandom_range(0, 3), 1'b0);
      else if (pick < 8) send_byte(8'($urandom));
      else               send_sym(10'($urandom), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
